// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants for the data-memory port arbiter: default
//               memory word/address widths, arbiter state encoding, lock
//               counter width and the requester-index width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Default memory geometry (1000-word memory -> 10 address bits).
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;

    // Arbiter state encoding.
    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_LOCKED = 1'b1;

    // Wide enough to count up to the largest legal MAX_LOCK (15).
    localparam int LOCK_CNT_WIDTH = 4;

    // Bits needed to hold a requester index; never less than one.
    function automatic int req_idx_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit found searching upward from ptr with wrap-around.
// Ports       : req        [NUM_REQ] in  - request vector
//               ptr        [IDX_W]   in  - highest-priority index
//               gnt_onehot [NUM_REQ] out - one-hot pick (0 when req=0)
//               gnt_idx    [IDX_W]   out - binary index of the pick
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = mem_pkg::req_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        sum        = '0;
        cand       = '0;
        found      = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous memory port between NUM_REQ
//               requesters. Round-robin arbitration with an optional bounded
//               lock for bursts; read data returns one cycle after the grant,
//               tagged by a one-hot rvalid.
// Ports       : clk, reset_n (sync, active-low)
//               req/we/lock [NUM_REQ]            in  - per-requester controls
//               addr  [NUM_REQ*ADDR_WIDTH]       in  - packed addresses
//               wdata [NUM_REQ*DATA_WIDTH]       in  - packed write data
//               gnt    [NUM_REQ]                 out - one-hot grant
//               rvalid [NUM_REQ]                 out - one-hot read return
//               rdata  [DATA_WIDTH]              out - broadcast read data
//               mem_wr_en/mem_addr/mem_wr_data   out - memory port drive
//               mem_rd_data [DATA_WIDTH]         in  - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int MAX_LOCK   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data
);

    import mem_pkg::*;

    localparam int IDX_W = req_idx_width(NUM_REQ);
    localparam logic [LOCK_CNT_WIDTH-1:0] MAX_LOCK_C = LOCK_CNT_WIDTH'(MAX_LOCK);
    localparam logic [LOCK_CNT_WIDTH-1:0] CNT_ONE    = LOCK_CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                      state_q,    state_d;
    logic [IDX_W-1:0]          owner_q,    owner_d;
    logic [IDX_W-1:0]          ptr_q,      ptr_d;
    logic [LOCK_CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]        rvalid_q,   rvalid_d;

    // ------------------------------------------------------------------
    // Grant datapath signals
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               owner_hit;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = gnt & ~we;

        if (owner_hit) begin
            // Owner served again: release on dropped lock or when this grant
            // is the last one the lock budget allows.
            if (!lock[owner_q] || (lock_cnt_q + CNT_ONE == MAX_LOCK_C)) begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
                ptr_d      = next_idx(owner_q);
            end else begin
                lock_cnt_d = lock_cnt_q + CNT_ONE;
            end
        end else begin
            // A locked owner that withdrew its request releases here; any
            // grant made this cycle came from the round-robin picker and is
            // handled exactly like an idle-state grant below.
            if (state_q == ARB_LOCKED) begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
                ptr_d      = next_idx(owner_q);
            end
            if (gnt_any) begin
                if (lock[gnt_idx] && (MAX_LOCK > 1)) begin
                    state_d    = ARB_LOCKED;
                    owner_d    = gnt_idx;
                    lock_cnt_d = CNT_ONE;
                end else begin
                    ptr_d = next_idx(gnt_idx);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_onehot[i] = (owner_q == IDX_W'(i));
        end
    end

    always_comb begin
        owner_hit = (state_q == ARB_LOCKED) && req[owner_q];
        // reset_n gates the grant so nothing reaches the memory during reset.
        gnt_any   = reset_n && (owner_hit || (|req));
        gnt_idx   = owner_hit ? owner_q : pick_idx;

        gnt = '0;
        if (gnt_any) begin
            gnt = owner_hit ? owner_onehot : pick_onehot;
        end

        mem_addr    = '0;
        mem_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr    = mem_addr    | addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_data = mem_wr_data | wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        mem_wr_en = gnt_any && we[gnt_idx];

        // A pending read return is suppressed as soon as reset is asserted.
        rvalid = reset_n ? rvalid_q : '0;
        rdata  = mem_rd_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               with literal expectations plus randomized traffic checked
//               every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 10;
    localparam int MAX_LOCK   = 4;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req, we, lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt, rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          mem_wr_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wr_data;
    logic [DATA_WIDTH-1:0]         mem_rd_data;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_LOCK   (MAX_LOCK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .we          (we),
        .lock        (lock),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory with a registered read (read-first).
    logic [DATA_WIDTH-1:0] mem [1024];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr];
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic bit_of(input logic [NUM_REQ-1:0] v, input int i);
        logic [NUM_REQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // ------------------------------------------------------------------
    // Reference model: owner/ptr/lock count as plain integers, a shadow
    // memory of every word written through the arbiter.
    // ------------------------------------------------------------------
    int                    m_owner = -1;
    int                    m_cnt   = 0;
    int                    m_ptr   = 0;
    logic [NUM_REQ-1:0]    m_rv    = '0;
    logic [DATA_WIDTH-1:0] m_rd    = '0;
    bit                    m_rd_known = 1'b0;
    logic [DATA_WIDTH-1:0] m_shadow [1024];
    bit                    m_known  [1024];

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    end

    always @(negedge clk) begin
        int                    g;
        logic [NUM_REQ-1:0]    eg;
        logic                  ewe;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] ed;
        logic [NUM_REQ-1:0]    erv;

        // Who must be granted this cycle.
        g = -1;
        if (reset_n === 1'b1) begin
            if (m_owner >= 0 && bit_of(req, m_owner)) begin
                g = m_owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && bit_of(req, (m_ptr + k) % NUM_REQ)) g = (m_ptr + k) % NUM_REQ;
                end
            end
        end

        eg  = '0;
        ewe = 1'b0;
        ea  = '0;
        ed  = '0;
        if (g >= 0) begin
            eg  = NUM_REQ'(1) << g;
            ewe = bit_of(we, g);
            ea  = ADDR_WIDTH'(addr >> (g * ADDR_WIDTH));
            ed  = DATA_WIDTH'(wdata >> (g * DATA_WIDTH));
        end
        erv = (reset_n === 1'b1) ? m_rv : '0;

        check("model gnt",       32'(gnt),       32'(eg));
        check("model wr_en",     32'(mem_wr_en), 32'(ewe));
        check("model mem_addr",  32'(mem_addr),  32'(ea));
        check("model mem_wdata", 32'(mem_wr_data), 32'(ed));
        check("model rvalid",    32'(rvalid),    32'(erv));
        if (erv != '0 && m_rd_known) check("model rdata", 32'(rdata), 32'(m_rd));

        // Advance to the state after the coming rising edge.
        if (reset_n !== 1'b1) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            m_rv    = '0;
        end else begin
            m_rv = '0;
            if (g >= 0) begin
                if (ewe) begin
                    m_shadow[ea] = ed;
                    m_known[ea]  = 1'b1;
                end else begin
                    m_rv       = eg;
                    m_rd       = m_shadow[ea];
                    m_rd_known = m_known[ea];
                end
            end
            if (m_owner >= 0 && g == m_owner) begin
                m_cnt++;
                if (!bit_of(lock, g) || m_cnt == MAX_LOCK) begin
                    m_owner = -1;
                    m_cnt   = 0;
                    m_ptr   = (g + 1) % NUM_REQ;
                end
            end else begin
                if (m_owner >= 0) begin
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                    m_cnt   = 0;
                end
                if (g >= 0) begin
                    if (bit_of(lock, g) && MAX_LOCK > 1) begin
                        m_owner = g;
                        m_cnt   = 1;
                    end else begin
                        m_ptr = (g + 1) % NUM_REQ;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic rn, input logic [NUM_REQ-1:0] r,
                         input logic [NUM_REQ-1:0] w, input logic [NUM_REQ-1:0] l);
        @(posedge clk);
        #1;
        reset_n = rn;
        req     = r;
        we      = w;
        lock    = l;
    endtask

    task automatic set_port(input int i, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = a;
        wdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic lit(input string nm, input logic [NUM_REQ-1:0] g_exp, input logic [NUM_REQ-1:0] rv_exp);
        @(negedge clk);
        check({nm, " gnt"},    32'(gnt),    32'(g_exp));
        check({nm, " rvalid"}, 32'(rvalid), 32'(rv_exp));
    endtask

    logic [NUM_REQ-1:0]    seq_g [4];
    logic [DATA_WIDTH-1:0] seq_d [4];

    initial begin
        reset_n = 1'b0;
        req     = '0;
        we      = '0;
        lock    = '0;
        addr    = '0;
        wdata   = '0;

        // Reset held with everyone requesting writes: nothing granted.
        repeat (3) begin
            drive(1'b0, 3'b111, 3'b111, 3'b000);
            set_port(0, 10'd5, 16'h1111);
            set_port(1, 10'd6, 16'h2222);
            set_port(2, 10'd7, 16'h3333);
            lit("reset", 3'b000, 3'b000);
            check("reset wr_en", 32'(mem_wr_en), 32'd0);
        end

        // First grants after reset start at requester 0; preload 5/6/7.
        drive(1'b1, 3'b111, 3'b111, 3'b000);
        lit("first", 3'b001, 3'b000);
        check("first wr_en", 32'(mem_wr_en), 32'd1);
        drive(1'b1, 3'b110, 3'b110, 3'b000);
        lit("pre1", 3'b010, 3'b000);
        drive(1'b1, 3'b100, 3'b100, 3'b000);
        lit("pre2", 3'b100, 3'b000);

        // Continuous reads by all three: rotation and tagged returns.
        seq_g[0] = 3'b001; seq_g[1] = 3'b010; seq_g[2] = 3'b100; seq_g[3] = 3'b001;
        seq_d[0] = 16'h1111; seq_d[1] = 16'h2222; seq_d[2] = 16'h3333; seq_d[3] = 16'h1111;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'b111, 3'b000, 3'b000);
            lit("rr", seq_g[k], (k == 0) ? 3'b000 : seq_g[k-1]);
            if (k > 0) check("rr rdata", 32'(rdata), 32'(seq_d[k-1]));
        end

        // Write then read-back by requester 1.
        drive(1'b1, 3'b010, 3'b010, 3'b000);
        set_port(1, 10'd12, 16'hBEEF);
        lit("wr", 3'b010, 3'b001);
        check("wr rdata",  32'(rdata),       32'h1111);
        check("wr wr_en",  32'(mem_wr_en),   32'd1);
        check("wr addr",   32'(mem_addr),    32'd12);
        check("wr wdata",  32'(mem_wr_data), 32'hBEEF);
        drive(1'b1, 3'b010, 3'b000, 3'b000);
        lit("rd", 3'b010, 3'b000);
        drive(1'b1, 3'b000, 3'b000, 3'b000);
        lit("rdret", 3'b000, 3'b010);
        check("rdret rdata", 32'(rdata), 32'hBEEF);

        // Bring ptr back to 0, then a full-length lock by requester 0.
        drive(1'b1, 3'b100, 3'b000, 3'b000);
        lit("align1", 3'b100, 3'b000);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'b101, 3'b000, 3'b001);
            lit("lock", 3'b001, (k == 0) ? 3'b100 : 3'b001);
        end
        drive(1'b1, 3'b101, 3'b000, 3'b001);
        lit("lockend", 3'b100, 3'b001);
        drive(1'b1, 3'b001, 3'b000, 3'b000);
        lit("lockafter", 3'b001, 3'b100);

        // Owner 0 locked for two grants, then withdraws while 1 and 2 wait.
        drive(1'b1, 3'b100, 3'b000, 3'b000);
        lit("align2", 3'b100, 3'b001);
        drive(1'b1, 3'b001, 3'b000, 3'b001);
        lit("lk1", 3'b001, 3'b100);
        drive(1'b1, 3'b001, 3'b000, 3'b001);
        lit("lk2", 3'b001, 3'b001);
        drive(1'b1, 3'b110, 3'b000, 3'b000);
        lit("rel", 3'b010, 3'b001);
        drive(1'b1, 3'b100, 3'b000, 3'b000);
        lit("rel2", 3'b100, 3'b010);

        // Reset right after a granted read kills the return and the pointer.
        drive(1'b1, 3'b001, 3'b000, 3'b000);
        lit("prerst", 3'b001, 3'b100);
        drive(1'b0, 3'b111, 3'b000, 3'b000);
        lit("midrst", 3'b000, 3'b000);
        drive(1'b1, 3'b111, 3'b000, 3'b000);
        lit("postrst", 3'b001, 3'b000);

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 2000; n++) begin
            logic [NUM_REQ-1:0] r, w, l;
            for (int i = 0; i < NUM_REQ; i++) begin
                r[i] = ($urandom_range(0, 3) != 0);
                w[i] = ($urandom_range(0, 2) == 0);
                l[i] = ($urandom_range(0, 2) == 0);
            end
            drive(($urandom_range(0, 149) != 0), r, w, l);
            for (int i = 0; i < NUM_REQ; i++) begin
                set_port(i,
                         ($urandom_range(0, 15) == 0) ? ADDR_WIDTH'($urandom_range(1000, 1023))
                                                      : ADDR_WIDTH'($urandom_range(0, 31)),
                         DATA_WIDTH'($urandom));
            end
        end

        drive(1'b1, 3'b000, 3'b000, 3'b000);
        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
